// File: rtl/keylock_core.sv
// keylock_core: N-digit BCD code lock with master/user codes, confirmed code change and auto-relock.
// Define KEYLOCK_LOCKOUT_EN to add the failed-attempt LOCKOUT state and its timer.
module keylock_core #(
  parameter int                  DIGITS         = 6,
  parameter logic [4*DIGITS-1:0] MASTER_CODE    = 24'h555116,
  parameter logic [4*DIGITS-1:0] USER_CODE_INIT = 24'h666666,
  parameter int                  OPEN_CYCLES    = 60000000,
  parameter int                  MAX_ATTEMPTS   = 3,
  parameter int                  LOCKOUT_CYCLES = 36000000
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  input  logic       lock_req,
  output logic       unlocked,
  output logic       prog_mode,
  output logic       error,
  output logic       code_changed,
  output logic       lockout,
  output logic [3:0] digit_count,
  output logic [3:0] attempts_left,
  output logic [2:0] stateDbg
);

  localparam int BW = 4 * DIGITS;
  localparam logic [3:0] FULL      = 4'(DIGITS);
  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;
  localparam logic [3:0] ATT_MAX   = 4'(MAX_ATTEMPTS);
  localparam int OPEN_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [OPEN_W-1:0] OPEN_LAST = (OPEN_CYCLES > 0) ? OPEN_W'(OPEN_CYCLES - 1) : '0;
`ifdef KEYLOCK_LOCKOUT_EN
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    OPEN     = 3'd1,
    NEW_CODE = 3'd2,
    CONFIRM  = 3'd3
`ifdef KEYLOCK_LOCKOUT_EN
    , LOCKOUT = 3'd4
`endif
  } stateT;

  stateT             state, stateNext;
  logic [BW-1:0]     codeBuf, bufNext;
  logic [BW-1:0]     candidate, candNext;
  logic [BW-1:0]     userCode, userNext;
  logic [3:0]        digitCnt, cntNext;
  logic              overrun, ovrNext;
  logic [OPEN_W-1:0] openCnt, openCntNext;
  logic              errNext, chgNext;
`ifdef KEYLOCK_LOCKOUT_EN
  logic [3:0]        attempts, attNext;
  logic [LOCK_W-1:0] lockCnt, lockCntNext;
`endif

  // key_valid is a one-cycle strobe with no backpressure: every strobed key is consumed
  // in the cycle it is presented, or deliberately dropped.
  logic          isDigit, isStar, isEnter, entryOk;
  logic [BW+3:0] shiftWide;
  logic [BW-1:0] shifted;

  assign isDigit   = key_valid && (key_code <= 4'd9);
  assign isStar    = key_valid && (key_code == KEY_STAR);
  assign isEnter   = key_valid && (key_code == KEY_ENTER);
  assign entryOk   = (digitCnt == FULL) && !overrun;
  assign shiftWide = {codeBuf, key_code};
  assign shifted   = shiftWide[BW-1:0];

  always_comb begin
    stateNext   = state;
    bufNext     = codeBuf;
    cntNext     = digitCnt;
    ovrNext     = overrun;
    candNext    = candidate;
    userNext    = userCode;
    openCntNext = openCnt;
    errNext     = 1'b0;
    chgNext     = 1'b0;
`ifdef KEYLOCK_LOCKOUT_EN
    attNext     = attempts;
    lockCntNext = lockCnt;
`endif
    unique case (state)
      LOCKED, NEW_CODE, CONFIRM: begin
        if (isDigit) begin
          // A full buffer keeps its contents; the extra digit only poisons the entry.
          if (digitCnt == FULL) begin
            ovrNext = 1'b1;
          end else begin
            bufNext = shifted;
            cntNext = digitCnt + 4'd1;
          end
        end else if (isStar || isEnter) begin
          bufNext = '0;
          cntNext = '0;
          ovrNext = 1'b0;
          if (isStar && (digitCnt == 4'd0) && (state != LOCKED)) begin
            stateNext = LOCKED;
          end
          if (isEnter) begin
            case (state)
              LOCKED: begin
                if (digitCnt != 4'd0) begin
                  if (entryOk && (codeBuf == userCode)) begin
                    stateNext   = OPEN;
                    openCntNext = '0;
`ifdef KEYLOCK_LOCKOUT_EN
                    attNext     = ATT_MAX;
`endif
                  end else if (entryOk && (codeBuf == MASTER_CODE)) begin
                    stateNext = NEW_CODE;
`ifdef KEYLOCK_LOCKOUT_EN
                    attNext   = ATT_MAX;
`endif
                  end else begin
                    errNext = 1'b1;
`ifdef KEYLOCK_LOCKOUT_EN
                    attNext = (attempts == 4'd0) ? 4'd0 : attempts - 4'd1;
                    if (attempts <= 4'd1) begin
                      stateNext   = LOCKOUT;
                      lockCntNext = '0;
                    end
`endif
                  end
                end
              end
              NEW_CODE: begin
                if (entryOk && (codeBuf != MASTER_CODE)) begin
                  candNext  = codeBuf;
                  stateNext = CONFIRM;
                end else begin
                  errNext   = 1'b1;
                  stateNext = LOCKED;
                end
              end
              CONFIRM: begin
                if (entryOk && (codeBuf == candidate)) begin
                  userNext = candidate;
                  chgNext  = 1'b1;
                end else begin
                  errNext = 1'b1;
                end
                stateNext = LOCKED;
              end
              default: ;
            endcase
          end
        end
      end
      OPEN: begin
        // lock_req outranks any key strobed in the same cycle.
        if (lock_req) begin
          stateNext = LOCKED;
        end else if ((OPEN_CYCLES != 0) && (openCnt == OPEN_LAST)) begin
          stateNext = LOCKED;
        end else if (isEnter) begin
          stateNext = LOCKED;
        end else begin
          openCntNext = openCnt + 1'b1;
        end
      end
`ifdef KEYLOCK_LOCKOUT_EN
      LOCKOUT: begin
        if (lockCnt == LOCK_LAST) begin
          stateNext = LOCKED;
          attNext   = ATT_MAX;
        end else begin
          lockCntNext = lockCnt + 1'b1;
        end
      end
`endif
      default: stateNext = LOCKED;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state        <= LOCKED;
      codeBuf      <= '0;
      digitCnt     <= '0;
      overrun      <= 1'b0;
      candidate    <= '0;
      userCode     <= USER_CODE_INIT;
      openCnt      <= '0;
      unlocked     <= 1'b0;
      prog_mode    <= 1'b0;
      error        <= 1'b0;
      code_changed <= 1'b0;
`ifdef KEYLOCK_LOCKOUT_EN
      attempts     <= ATT_MAX;
      lockCnt      <= '0;
      lockout      <= 1'b0;
`endif
    end else begin
      state        <= stateNext;
      codeBuf      <= bufNext;
      digitCnt     <= cntNext;
      overrun      <= ovrNext;
      candidate    <= candNext;
      userCode     <= userNext;
      openCnt      <= openCntNext;
      unlocked     <= (stateNext == OPEN);
      prog_mode    <= (stateNext == NEW_CODE) || (stateNext == CONFIRM);
      error        <= errNext;
      code_changed <= chgNext;
`ifdef KEYLOCK_LOCKOUT_EN
      attempts     <= attNext;
      lockCnt      <= lockCntNext;
      lockout      <= (stateNext == LOCKOUT);
`endif
    end
  end

  assign digit_count = digitCnt;
  assign stateDbg    = state;
`ifdef KEYLOCK_LOCKOUT_EN
  assign attempts_left = attempts;
`else
  assign attempts_left = ATT_MAX;
  assign lockout       = 1'b0;
`endif

endmodule

// File: tb/tb_keylock_core.sv
// Scoreboarded bench for keylock_core (DIGITS=4, master 5551, user 6666, relock 100, lockout 50).
module tb_keylock_core;

  localparam int W = 9;
  localparam logic [2:0] ST_LOCKED  = 3'd0;
  localparam logic [2:0] ST_CONFIRM = 3'd3;

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_code = 4'd0;
  logic       key_valid = 1'b0;
  logic       lock_req = 1'b0;
  logic       unlocked, prog_mode, error, code_changed, lockout;
  logic [3:0] digit_count, attempts_left;
  logic [2:0] stateDbg;

  keylock_core #(
    .DIGITS(4), .MASTER_CODE(16'h5551), .USER_CODE_INIT(16'h6666),
    .OPEN_CYCLES(100), .MAX_ATTEMPTS(3), .LOCKOUT_CYCLES(50)
  ) dut (
    .hwclk(hwclk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
    .lock_req(lock_req), .unlocked(unlocked), .prog_mode(prog_mode), .error(error),
    .code_changed(code_changed), .lockout(lockout), .digit_count(digit_count),
    .attempts_left(attempts_left), .stateDbg(stateDbg)
  );

  // clock / reset
  always #5 hwclk = ~hwclk;

  int cyc = 0;
  always @(posedge hwclk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int fails = 0;
  bit mon_on = 1'b0;
  logic pU = 1'b0, pP = 1'b0, pL = 1'b0;

  function automatic logic [W-1:0] ev(bit u, bit p, bit e, bit c, bit l, int a);
    return {u, p, e, c, l, 4'(a)};
  endfunction

  function automatic int att(int n);
`ifdef KEYLOCK_LOCKOUT_EN
    return n;
`else
    return 3;
`endif
  endfunction

  always @(negedge hwclk) begin : monitor
    logic [W-1:0] got, want;
    if (mon_on && (error || code_changed || unlocked !== pU || prog_mode !== pP || lockout !== pL)) begin
      got = {unlocked, prog_mode, error, code_changed, lockout, attempts_left};
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got {unl,prog,err,chg,lo,att}=%b, none expected, cycle %0d", got, cyc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL event: got {unl,prog,err,chg,lo,att}=%b expected %b, cycle %0d", got, want, cyc);
        end
      end
    end
    pU = unlocked;
    pP = prog_mode;
    pL = lockout;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h, cycle %0d", name, got, want, cyc);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge hwclk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // driver tasks
  task automatic press(input logic [3:0] k);
    @(negedge hwclk);
    key_code = k;
    key_valid = 1'b1;
    @(negedge hwclk);
    key_valid = 1'b0;
  endtask

  task automatic code4(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    press(4'd11);
  endtask

  task automatic lock_pulse();
    @(negedge hwclk);
    lock_req = 1'b1;
    @(negedge hwclk);
    lock_req = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_unlocked", unlocked, 0);
    chk("rst_prog_mode", prog_mode, 0);
    chk("rst_error", error, 0);
    chk("rst_code_changed", code_changed, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_digit_count", digit_count, 0);
    chk("rst_attempts", attempts_left, 3);
    chk("rst_state", stateDbg, ST_LOCKED);
  endtask

  task automatic do_reset();
    drain();
    mon_on = 1'b0;
    @(negedge hwclk);
    reset = 1'b1;
    @(negedge hwclk);
    @(negedge hwclk);
    reset = 1'b0;
    check_reset_values();
    mon_on = 1'b1;
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge hwclk);
    reset = 1'b0;
    check_reset_values();
    mon_on = 1'b1;

    // user code opens, auto-relock exactly 100 cycles later
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3));
    code4(16'h6666);
    chk("open_after_enter", unlocked, 1);
    t0 = cyc;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 3));
    while (cyc < t0 + 99) @(negedge hwclk);
    chk("still_open_99", unlocked, 1);
    @(negedge hwclk);
    chk("relocked_100", unlocked, 0);
    drain();

    // '#' on empty buffer and ignored key codes in LOCKED
    press(4'd11);
    chk("empty_enter_err", error, 0);
    chk("empty_enter_att", attempts_left, 3);
    press(4'd12);
    press(4'd15);
    chk("ignored_keys_cnt", digit_count, 0);

    // program 1234, then it opens and 6666 fails
    exp_q.push_back(ev(0, 1, 0, 0, 0, 3));
    code4(16'h5551);
    code4(16'h1234);
    chk("in_confirm", stateDbg, ST_CONFIRM);
    exp_q.push_back(ev(0, 0, 0, 1, 0, 3));
    code4(16'h1234);
    chk("after_commit_state", stateDbg, ST_LOCKED);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3));
    code4(16'h1234);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 3));
    lock_pulse();
    exp_q.push_back(ev(0, 0, 1, 0, 0, att(2)));
    code4(16'h6666);

    // confirm mismatch leaves 6666; master as new code rejected; '*' abort
    do_reset();
    exp_q.push_back(ev(0, 1, 0, 0, 0, 3));
    code4(16'h5551);
    code4(16'h1234);
    exp_q.push_back(ev(0, 0, 1, 0, 0, 3));
    code4(16'h1235);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3));
    code4(16'h6666);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 3));
    lock_pulse();
    exp_q.push_back(ev(0, 1, 0, 0, 0, 3));
    code4(16'h5551);
    exp_q.push_back(ev(0, 0, 1, 0, 0, 3));
    code4(16'h5551);
    exp_q.push_back(ev(0, 1, 0, 0, 0, 3));
    code4(16'h5551);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 3));
    press(4'd10);
    drain();

    // overrun, short entry, '*' recovery
    for (int i = 0; i < 5; i++) press(4'd6);
    chk("overrun_cnt", digit_count, 4);
    exp_q.push_back(ev(0, 0, 1, 0, 0, att(2)));
    press(4'd11);
    press(4'd6);
    press(4'd6);
    chk("short_cnt", digit_count, 2);
    exp_q.push_back(ev(0, 0, 1, 0, 0, att(1)));
    press(4'd11);
    press(4'd6);
    press(4'd6);
    press(4'd10);
    chk("star_clear_cnt", digit_count, 0);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3));
    code4(16'h6666);

    // lock_req and '#' together in OPEN
    exp_q.push_back(ev(0, 0, 0, 0, 0, 3));
    @(negedge hwclk);
    lock_req = 1'b1;
    key_code = 4'd11;
    key_valid = 1'b1;
    @(negedge hwclk);
    lock_req = 1'b0;
    key_valid = 1'b0;
    chk("lockreq_state", stateDbg, ST_LOCKED);
    chk("lockreq_no_error", error, 0);
    drain();

`ifdef KEYLOCK_LOCKOUT_EN
    // three failures enter lockout; keys and lock_req ignored; timed exit
    do_reset();
    exp_q.push_back(ev(0, 0, 1, 0, 0, 2));
    code4(16'h1111);
    exp_q.push_back(ev(0, 0, 1, 0, 0, 1));
    code4(16'h1111);
    exp_q.push_back(ev(0, 0, 1, 0, 1, 0));
    code4(16'h1111);
    chk("lockout_on", lockout, 1);
    t0 = cyc;
    code4(16'h6666);
    lock_pulse();
    chk("lockout_keys_cnt", digit_count, 0);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 3));
    while (cyc < t0 + 49) @(negedge hwclk);
    chk("lockout_49", lockout, 1);
    @(negedge hwclk);
    chk("lockout_50", lockout, 0);
    chk("lockout_att", attempts_left, 3);
    drain();
`endif

    // reset in CONFIRM discards the candidate
    exp_q.push_back(ev(0, 1, 0, 0, 0, 3));
    code4(16'h5551);
    code4(16'h4321);
    chk("pre_reset_confirm", stateDbg, ST_CONFIRM);
    do_reset();
    exp_q.push_back(ev(0, 0, 1, 0, 0, att(2)));
    code4(16'h4321);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3));
    code4(16'h6666);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 3));
    lock_pulse();
    drain();
    repeat (3) @(negedge hwclk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
